// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load extension ops, store size patterns,
// access FSM states and the alignment rule.
package mem_pkg;

  typedef enum logic [2:0] {
    EXT_LW  = 3'd0,
    EXT_LB  = 3'd1,
    EXT_LBU = 3'd2,
    EXT_LH  = 3'd3,
    EXT_LHU = 3'd4
  } ext_op_e;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_SB   = 4'b0001;
  localparam logic [3:0] WEN_SH   = 4'b0011;
  localparam logic [3:0] WEN_SW   = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic misaligned(input logic mem_rd, input logic [3:0] wen,
                                      input logic [2:0] ext_op, input logic [1:0] off);
    logic is_word, is_half;
    is_word = (mem_rd && ext_op == EXT_LW) || (!mem_rd && wen == WEN_SW);
    is_half = (mem_rd && (ext_op == EXT_LH || ext_op == EXT_LHU)) || (!mem_rd && wen == WEN_SH);
    return (is_word && off != 2'b00) || (is_half && off[0]);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load byte/half lane select and sign/zero extension (combinational).
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      ext_op,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = rdata[{off[1], 4'b0000} +: 16];
    case (ext_op)
      EXT_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      EXT_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      EXT_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
      EXT_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory access with timeout,
// store lane alignment, load extension and WB output register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [31:0]     ex_inst,
  input  logic            ex_write_reg,
  input  logic [4:0]      ex_write_dst,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_mem_rd,
  input  logic [3:0]      ex_wen,
  input  logic [2:0]      ex_ext_op,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_exc,
  input  logic            flush,
  output logic            dmem_req,
  output logic [3:0]      dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [31:0]     wb_inst,
  output logic            wb_write_reg,
  output logic [4:0]      wb_write_dst,
  output logic [XLEN-1:0] wb_write_data,
  output logic            wb_addr_fault,
  output logic [XLEN-1:0] wb_bad_vaddr,
  output logic            wb_bus_err
);

  logic            m_valid, m_write_reg, m_mem_rd, m_fault, m_exc, m_issue;
  logic [4:0]      m_write_dst;
  logic [2:0]      m_ext_op;
  logic [3:0]      m_we;
  logic [31:0]     m_inst;
  logic [XLEN-1:0] m_pc, m_result, m_addr, m_wdata;

  mem_state_e      state;
  logic [7:0]      wait_cnt;
  logic            pend;

  logic            capture, ex_live, ex_fault, ex_issue, acked, timeout, retire;
  logic [XLEN-1:0] ex_wdata_al, load_data;

  // pend covers the one cycle between an ack and the re-issue of an op captured on that ack edge
  assign mem_stall = (dmem_req & ~dmem_ack) | pend;
  assign capture   = ~mem_stall;
  assign ex_live   = ex_valid & ~flush;
  assign ex_fault  = misaligned(ex_mem_rd, ex_wen, ex_ext_op, ex_addr[1:0]);
  assign ex_issue  = ex_live & ~ex_exc & ~ex_fault & (ex_mem_rd | (ex_wen != WEN_NONE));
  assign acked     = (state == ST_ACCESS) & dmem_ack;
  assign timeout   = (state == ST_ACCESS) & ~dmem_ack & (wait_cnt == 8'(MAX_WAIT - 1));
  assign retire    = m_valid & (m_issue ? (acked | timeout) : 1'b1);

  assign dmem_addr  = {m_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata = m_wdata;
  assign dmem_we    = dmem_req ? m_we : 4'b0000;

  always_comb begin
    ex_wdata_al = ex_wdata;
    if (ex_wen == WEN_SB)      ex_wdata_al = {(XLEN/8){ex_wdata[7:0]}};
    else if (ex_wen == WEN_SH) ex_wdata_al = {(XLEN/16){ex_wdata[15:0]}};
  end

  mem_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata  (dmem_rdata),
    .off    (m_addr[1:0]),
    .ext_op (m_ext_op),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_write_reg <= 1'b0;
      m_mem_rd    <= 1'b0;
      m_fault     <= 1'b0;
      m_exc       <= 1'b0;
      m_issue     <= 1'b0;
      m_write_dst <= '0;
      m_ext_op    <= '0;
      m_we        <= '0;
      m_inst      <= '0;
      m_pc        <= '0;
      m_result    <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
    end else if (capture) begin
      m_valid     <= ex_live;
      m_write_reg <= ex_live & ex_write_reg;
      m_mem_rd    <= ex_live & ex_mem_rd;
      m_fault     <= ex_live & ex_fault;
      m_exc       <= ex_live & ex_exc;
      m_issue     <= ex_issue;
      m_we        <= ex_live ? (ex_wen << ex_addr[1:0]) : 4'b0000;
      m_write_dst <= ex_write_dst;
      m_ext_op    <= ex_ext_op;
      m_inst      <= ex_inst;
      m_pc        <= ex_pc;
      m_result    <= ex_result;
      m_addr      <= ex_addr;
      m_wdata     <= ex_wdata_al;
    end else if (retire) begin
      m_valid <= 1'b0;
      m_issue <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dmem_req <= 1'b0;
      pend     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (pend) begin
            state    <= ST_ACCESS;
            dmem_req <= 1'b1;
            pend     <= 1'b0;
          end else if (capture && ex_issue) begin
            state    <= ST_ACCESS;
            dmem_req <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack || timeout) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            wait_cnt <= '0;
            pend     <= dmem_ack & ex_issue;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_pc         <= '0;
      wb_inst       <= '0;
      wb_write_reg  <= 1'b0;
      wb_write_dst  <= '0;
      wb_write_data <= '0;
      wb_addr_fault <= 1'b0;
      wb_bad_vaddr  <= '0;
      wb_bus_err    <= 1'b0;
    end else begin
      wb_valid <= retire;
      if (retire) begin
        wb_pc         <= m_pc;
        wb_inst       <= m_inst;
        wb_write_dst  <= m_write_dst;
        wb_write_reg  <= m_write_reg & ~m_fault & ~m_exc & ~timeout;
        wb_write_data <= (m_mem_rd && acked) ? load_data : m_result;
        wb_addr_fault <= m_fault;
        wb_bad_vaddr  <= m_fault ? m_addr : '0;
        wb_bus_err    <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a scoreboard, plus hand-written
// back-to-back, flush, timeout and mid-access reset sequences.
module tb_mem_stage;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_write_reg, ex_mem_rd, ex_exc, flush, dmem_ack;
  logic [31:0] ex_pc, ex_inst, ex_result, ex_addr, ex_wdata, dmem_rdata;
  logic [4:0]  ex_write_dst;
  logic [3:0]  ex_wen;
  logic [2:0]  ex_ext_op;
  logic        dmem_req, mem_stall, wb_valid, wb_write_reg, wb_addr_fault, wb_bus_err;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, wb_pc, wb_inst, wb_write_data, wb_bad_vaddr;
  logic [4:0]  wb_write_dst;

  mem_stage #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_write_reg(ex_write_reg), .ex_write_dst(ex_write_dst), .ex_result(ex_result),
    .ex_mem_rd(ex_mem_rd), .ex_wen(ex_wen), .ex_ext_op(ex_ext_op), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_exc(ex_exc), .flush(flush), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .wb_write_reg(wb_write_reg), .wb_write_dst(wb_write_dst),
    .wb_write_data(wb_write_data), .wb_addr_fault(wb_addr_fault),
    .wb_bad_vaddr(wb_bad_vaddr), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem_rd;
    logic [3:0]  wen;
    logic [2:0]  ext_op;
    logic [31:0] addr, wdata, rdata, result;
    logic        wr;
    int          delay;
    logic        exp_req;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata, exp_data;
    logic        exp_fault, chk_data;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst;
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] data;
    logic        chk_data, fault;
    logic [31:0] bad;
    logic        bus_err;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mem_rd, input logic [3:0] wen, input logic [2:0] ext_op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [31:0] result, input logic wr,
                              input int delay, input logic exp_req, input logic [3:0] exp_we,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                              input logic exp_fault, input logic chk_data);
    vec_t v;
    v.mem_rd = mem_rd; v.wen = wen; v.ext_op = ext_op; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.result = result; v.wr = wr; v.delay = delay; v.exp_req = exp_req;
    v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
    v.exp_fault = exp_fault; v.chk_data = chk_data;
    return v;
  endfunction

  // WB monitor: every retirement must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_inst", wb_inst, e.inst);
        chk("wb_write_reg", 32'(wb_write_reg), 32'(e.wr));
        chk("wb_write_dst", 32'(wb_write_dst), 32'(e.dst));
        if (e.chk_data) chk("wb_write_data", wb_write_data, e.data);
        chk("wb_addr_fault", 32'(wb_addr_fault), 32'(e.fault));
        chk("wb_bad_vaddr", wb_bad_vaddr, e.bad);
        chk("wb_bus_err", 32'(wb_bus_err), 32'(e.bus_err));
      end
    end
  end

  task automatic drive_ex(input vec_t v, input int idx);
    ex_valid = 1'b1; ex_pc = 32'h1000 + (32'(idx) << 2); ex_inst = 32'hA000_0000 + 32'(idx);
    ex_write_reg = v.wr; ex_write_dst = 5'(idx + 1); ex_result = v.result;
    ex_mem_rd = v.mem_rd; ex_wen = v.wen; ex_ext_op = v.ext_op; ex_addr = v.addr;
    ex_wdata = v.wdata;
  endtask

  task automatic push_exp(input vec_t v, input int idx, input logic bus_err);
    exp_t e;
    e.pc = 32'h1000 + (32'(idx) << 2); e.inst = 32'hA000_0000 + 32'(idx);
    e.wr = v.wr & ~v.exp_fault & ~bus_err; e.dst = 5'(idx + 1); e.data = v.exp_data;
    e.chk_data = v.chk_data & ~bus_err; e.fault = v.exp_fault;
    e.bad = v.exp_fault ? v.addr : 32'h0; e.bus_err = bus_err;
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive_ex(v, idx);
    push_exp(v, idx, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.exp_we));
      if (v.exp_we != 4'b0000) chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
      for (int k = 0; k <= v.delay; k++) begin
        dmem_ack = (k == v.delay); dmem_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d_stall", idx), 32'(mem_stall), 32'(!dmem_ack));
        @(posedge clk); #1;
      end
    end else begin
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk($sformatf("v%0d_stall_idle_ack", idx), 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    chk($sformatf("v%0d_wb_latency", idx), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d_req_after", idx), 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_wb_pulse", idx), 32'(wb_valid), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vec_t v;
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0; ex_write_reg = 1'b0;
    ex_write_dst = '0; ex_result = '0; ex_mem_rd = 1'b0; ex_wen = '0; ex_ext_op = '0;
    ex_addr = '0; ex_wdata = '0; ex_exc = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;

    //              rd wen     ext   addr      wdata         rdata         result        wr d  req we      exp_wdata     exp_data      flt chk
    vecs[0]  = mk(1, 4'b0000, 3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 1);
    vecs[1]  = mk(1, 4'b0000, 3'd1, 32'h103, 32'h0,        32'h80123456, 32'h0,        1, 1, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 1);
    vecs[2]  = mk(1, 4'b0000, 3'd2, 32'h103, 32'h0,        32'h80123456, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        32'h00000080, 0, 1);
    vecs[3]  = mk(1, 4'b0000, 3'd4, 32'h102, 32'h0,        32'hBEEF1234, 32'h0,        1, 2, 1, 4'b0000, 32'h0,        32'h0000BEEF, 0, 1);
    vecs[4]  = mk(1, 4'b0000, 3'd3, 32'h100, 32'h0,        32'h12348001, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0, 1);
    vecs[5]  = mk(1, 4'b0000, 3'd1, 32'h101, 32'h0,        32'h00007F00, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        32'h0000007F, 0, 1);
    vecs[6]  = mk(0, 4'b0011, 3'd0, 32'h102, 32'h1234,     32'h0,        32'h55,       0, 0, 1, 4'b1100, 32'h12341234, 32'h55,       0, 1);
    vecs[7]  = mk(0, 4'b0001, 3'd0, 32'h101, 32'hAB,       32'h0,        32'h66,       0, 1, 1, 4'b0010, 32'hABABABAB, 32'h66,       0, 1);
    vecs[8]  = mk(0, 4'b1111, 3'd0, 32'h104, 32'hCAFEF00D, 32'h0,        32'h77,       0, 3, 1, 4'b1111, 32'hCAFEF00D, 32'h77,       0, 1);
    vecs[9]  = mk(1, 4'b0000, 3'd0, 32'h101, 32'h0,        32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
    vecs[10] = mk(0, 4'b0011, 3'd0, 32'h103, 32'h5678,     32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
    vecs[11] = mk(1, 4'b0000, 3'd4, 32'h101, 32'h0,        32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
    vecs[12] = mk(0, 4'b1111, 3'd0, 32'h102, 32'h1,        32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0);
    vecs[13] = mk(0, 4'b0000, 3'd0, 32'h0,   32'h0,        32'h0,        32'h12345678, 1, 0, 0, 4'b0000, 32'h0,        32'h12345678, 0, 1);
    vecs[14] = mk(1, 4'b0000, 3'd0, 32'h10C, 32'h0,        32'h01020304, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        32'h01020304, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_write_data, 32'd0);
    chk("rst_wb_bus_err", 32'(wb_bus_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // back-to-back LW then SW: SW captured on the ack edge, request drops one cycle
    v = mk(1, 4'b0000, 3'd0, 32'h100, 32'h0, 32'h11112222, 32'h0, 1, 0, 1, 4'b0000, 32'h0, 32'h11112222, 0, 1);
    drive_ex(v, 20); push_exp(v, 20, 1'b0);
    @(posedge clk); #1;
    chk("b2b_lw_req", 32'(dmem_req), 32'd1);
    v = mk(0, 4'b1111, 3'd0, 32'h104, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 1, 4'b1111, 32'h0BADF00D, 32'h0, 0, 1);
    drive_ex(v, 21); push_exp(v, 21, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h11112222;
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_ack = 1'b0;
    chk("b2b_gap_req", 32'(dmem_req), 32'd0);
    chk("b2b_gap_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    chk("b2b_sw_req", 32'(dmem_req), 32'd1);
    chk("b2b_sw_we", 32'(dmem_we), 32'hF);
    chk("b2b_sw_addr", dmem_addr, 32'h104);
    chk("b2b_sw_wdata", dmem_wdata, 32'h0BADF00D);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("b2b_sw_req_done", 32'(dmem_req), 32'd0);
    chk("b2b_sw_wb", 32'(wb_valid), 32'd1);
    @(posedge clk); #1;

    // flushed load: no request, no retirement
    v = mk(1, 4'b0000, 3'd0, 32'h200, 32'h0, 32'h0, 32'h0, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 0);
    drive_ex(v, 30); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0;
    chk("flush_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("flush_wb", 32'(wb_valid), 32'd0);

    // ack withheld: request held MAX_WAIT cycles then bus error
    v = mk(1, 4'b0000, 3'd0, 32'h300, 32'h0, 32'h0, 32'h0, 1, 0, 1, 4'b0000, 32'h0, 32'h0, 0, 0);
    drive_ex(v, 40); push_exp(v, 40, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    n = 0;
    while (dmem_req && n < 40) begin
      if (!mem_stall) chk("timeout_stall", 32'(mem_stall), 32'd1);
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", 32'(n), 32'(MAX_WAIT));
    chk("timeout_req_low", 32'(dmem_req), 32'd0);
    chk("timeout_wb_valid", 32'(wb_valid), 32'd1);
    chk("timeout_bus_err", 32'(wb_bus_err), 32'd1);
    @(posedge clk); #1;

    // reset in ACCESS cycle 3: outputs drop at once, access lost
    v = mk(1, 4'b0000, 3'd0, 32'h400, 32'h0, 32'h0, 32'h0, 1, 0, 1, 4'b0000, 32'h0, 32'h0, 0, 0);
    drive_ex(v, 50);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0], 51);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
